// File: rtl/membus_pkg.sv
// membus_pkg: shared state encoding, default error data and the address-window hit test
// for the membus_xbar router.
`default_nettype none

package membus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLV  = 2'd1,
    ST_INT  = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

`default_nettype wire

// File: rtl/membus_decode.sv
// membus_decode: combinational priority decode of a CPU address into halt / console /
// lowest-index external slave hit.
`default_nettype none

module membus_decode
  import membus_pkg::*;
#(
  parameter int              NSLV      = 3,
  parameter logic [NSLV*32-1:0] SLV_BASE = {NSLV{32'h0}},
  parameter logic [NSLV*32-1:0] SLV_MASK = {NSLV{32'hF000_0000}},
  parameter logic [31:0]     CON_ADDR  = 32'h9000_0000,
  parameter logic [31:0]     HALT_ADDR = 32'h8000_0000,
  parameter int              IDX_W     = 2
) (
  input  logic [31:0]      i_addr,
  output logic             o_is_halt,
  output logic             o_is_con,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_idx
);

  always_comb begin
    o_is_halt = (i_addr[31:2] == HALT_ADDR[31:2]);
    o_is_con  = (i_addr[31:2] == CON_ADDR[31:2]);
    o_hit     = 1'b0;
    o_idx     = '0;
    // Scan downwards so the lowest matching slot is the one left standing.
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (addr_hit(i_addr, SLV_BASE[32*i +: 32], SLV_MASK[32*i +: 32])) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/membus_xbar.sv
// membus_xbar: 1-to-NSLV picorv32 native-bus router with console/halt slave and error response.
// Rev 1.0. Optional slave watchdog enabled by defining MEMBUS_TIMEOUT_EN.
`default_nettype none

module membus_xbar
  import membus_pkg::*;
#(
  parameter int                 NSLV      = 3,
  parameter logic [NSLV*32-1:0] SLV_BASE  = {NSLV{32'h0}},
  parameter logic [NSLV*32-1:0] SLV_MASK  = {NSLV{32'hF000_0000}},
  parameter logic [31:0]        CON_ADDR  = 32'h9000_0000,
  parameter logic [31:0]        HALT_ADDR = 32'h8000_0000,
  parameter logic [31:0]        ERR_RDATA = ERR_RDATA_DEF,
  parameter int                 TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  input  logic [3:0]           mem_wstrb,
  output logic [31:0]          mem_rdata,
  output logic [NSLV-1:0]      s_valid,
  output logic [31:0]          s_addr,
  output logic [31:0]          s_wdata,
  output logic [3:0]           s_wstrb,
  input  logic [NSLV-1:0]      s_ready,
  input  logic [NSLV*32-1:0]   s_rdata,
  output logic                 con_valid,
  output logic [7:0]           con_data,
  output logic                 halt,
  output logic                 bus_err,
  output logic [31:0]          err_addr
);

  localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;

  state_e             r_state;
  logic [IDX_W-1:0]   r_sel;
  logic [NSLV-1:0]    r_svalid;
  logic               r_ready;
  logic [31:0]        r_rdata;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_wstrb;
  logic               r_con_valid;
  logic [7:0]         r_con_data;
  logic               r_halt;
  logic               r_bus_err;
  logic [31:0]        r_err_addr;

  logic               w_is_halt;
  logic               w_is_con;
  logic               w_hit;
  logic [IDX_W-1:0]   w_idx;
  logic               w_sel_ready;
  logic               w_expire;
  logic [31:0]        w_rdata_arr [NSLV];

  membus_decode #(
    .NSLV      (NSLV),
    .SLV_BASE  (SLV_BASE),
    .SLV_MASK  (SLV_MASK),
    .CON_ADDR  (CON_ADDR),
    .HALT_ADDR (HALT_ADDR),
    .IDX_W     (IDX_W)
  ) u_decode (
    .i_addr    (mem_addr),
    .o_is_halt (w_is_halt),
    .o_is_con  (w_is_con),
    .o_hit     (w_hit),
    .o_idx     (w_idx)
  );

  for (genvar g = 0; g < NSLV; g++) begin : g_rdata
    assign w_rdata_arr[g] = s_rdata[32*g +: 32];
  end

  assign w_sel_ready = s_ready[r_sel];

`ifdef MEMBUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] r_cnt;
  assign w_expire = (r_cnt == CNT_W'(TIMEOUT - 1));
`else
  // Without the watchdog a silent slave stalls the CPU indefinitely.
  assign w_expire = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sel       <= '0;
      r_svalid    <= '0;
      r_ready     <= 1'b0;
      r_rdata     <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_con_valid <= 1'b0;
      r_con_data  <= '0;
      r_halt      <= 1'b0;
      r_bus_err   <= 1'b0;
      r_err_addr  <= '0;
`ifdef MEMBUS_TIMEOUT_EN
      r_cnt       <= '0;
`endif
    end else begin
      r_con_valid <= 1'b0;
      r_bus_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (mem_valid) begin
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
            if (w_is_halt || w_is_con) begin
              r_state <= ST_INT;
              r_ready <= 1'b1;
              r_rdata <= '0;
              if (|mem_wstrb) begin
                if (w_is_halt) begin
                  r_halt <= 1'b1;
                end else begin
                  r_con_valid <= 1'b1;
                  r_con_data  <= mem_wdata[7:0];
                end
              end
            end else if (w_hit) begin
              r_state  <= ST_SLV;
              r_sel    <= w_idx;
              r_svalid <= NSLV'(1) << w_idx;
`ifdef MEMBUS_TIMEOUT_EN
              r_cnt    <= '0;
`endif
            end else begin
              r_state    <= ST_ERR;
              r_ready    <= 1'b1;
              r_rdata    <= ERR_RDATA;
              r_bus_err  <= 1'b1;
              r_err_addr <= mem_addr;
            end
          end
        end
        ST_SLV: begin
          // A ready arriving on the expiry cycle takes precedence over the timeout.
          if (w_sel_ready) begin
            r_state  <= ST_IDLE;
            r_svalid <= '0;
          end else if (w_expire) begin
            r_state    <= ST_ERR;
            r_svalid   <= '0;
            r_ready    <= 1'b1;
            r_rdata    <= ERR_RDATA;
            r_bus_err  <= 1'b1;
            r_err_addr <= r_addr;
          end
`ifdef MEMBUS_TIMEOUT_EN
          else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        ST_INT, ST_ERR: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_ready = (r_state == ST_SLV) ? w_sel_ready : r_ready;
  assign mem_rdata = (r_state == ST_SLV) ? w_rdata_arr[r_sel] : r_rdata;
  assign s_valid   = r_svalid;
  assign s_addr    = r_addr;
  assign s_wdata   = r_wdata;
  assign s_wstrb   = r_wstrb;
  assign con_valid = r_con_valid;
  assign con_data  = r_con_data;
  assign halt      = r_halt;
  assign bus_err   = r_bus_err;
  assign err_addr  = r_err_addr;

endmodule

`default_nettype wire

// File: tb/tb_membus_xbar.sv
// tb_membus_xbar: directed table, hand-written corner sequences and randomized traffic
// against an address-map reference model for membus_xbar.
`default_nettype none

module tb_membus_xbar;

  localparam logic [95:0] BASE = {32'h3000_0000, 32'h4000_0000, 32'h0000_0000};
  localparam logic [95:0] MASK = {32'h3000_0000, 32'hF000_0000, 32'hC000_0000};
  localparam logic [31:0] CON  = 32'h9000_0000;
  localparam logic [31:0] HLT  = 32'h8000_0000;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
  logic [3:0]  mem_wstrb = '0;
  logic [2:0]  s_valid, s_ready = '0;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [95:0] s_rdata = '0;
  logic        con_valid, halt, bus_err;
  logic [7:0]  con_data;
  logic [31:0] err_addr;

  membus_xbar #(
    .NSLV(3), .SLV_BASE(BASE), .SLV_MASK(MASK), .CON_ADDR(CON), .HALT_ADDR(HLT),
    .ERR_RDATA(ERRD), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata), .con_valid(con_valid), .con_data(con_data),
    .halt(halt), .bus_err(bus_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          lat  [3] = '{0, 0, 0};
  int          scnt [3] = '{0, 0, 0};
  logic [31:0] SEED [3] = '{32'hA5A5_0000, 32'h5A5A_0000, 32'h0F0F_0000};
  logic        m_halt = 1'b0;
  logic [31:0] m_err  = '0;

  // Behavioural slaves: answer after lat[i] wait cycles, data = address ^ seed.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      if (s_valid[i]) begin
        if (scnt[i] >= lat[i]) s_ready[i] = 1'b1;
        else begin
          s_ready[i] = 1'b0;
          scnt[i]++;
        end
      end else begin
        s_ready[i] = 1'b0;
        scnt[i]    = 0;
      end
      s_rdata[32*i +: 32] = s_addr ^ SEED[i];
    end
  end

  typedef struct {
    logic        done, multi, con, err, stray;
    logic [2:0]  sv_or;
    int          cyc, svc;
    logic [31:0] rdata, saddr, swdata;
    logic [7:0]  cdata;
    logic [3:0]  swstrb;
  } obs_t;

  typedef struct {
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    int          lat, exp_cyc;
    logic [2:0]  exp_sv;
    logic [31:0] exp_rdata;
    logic        exp_con;
    logic [7:0]  exp_cdata;
    logic        exp_err, exp_halt;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         output obs_t o);
    o = '{done: 0, multi: 0, con: 0, err: 0, stray: 0, sv_or: 0, cyc: 0, svc: 0,
          rdata: 0, saddr: 0, swdata: 0, cdata: 0, swstrb: 0};
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      o.sv_or |= s_valid;
      if ($countones(s_valid) > 1) o.multi = 1'b1;
      if (s_valid != 3'b000) o.svc++;
      if (mem_ready) begin
        o.done = 1'b1; o.cyc = c; o.rdata = mem_rdata;
        o.con = con_valid; o.cdata = con_data; o.err = bus_err;
        o.saddr = s_addr; o.swdata = s_wdata; o.swstrb = s_wstrb;
        break;
      end
      if (con_valid || bus_err) o.stray = 1'b1;
      // The routed address must stay latched even if the CPU bus wanders.
      mem_addr = ~a;
    end
    mem_valid = 1'b0;
  endtask

  task automatic check_txn(input string t, input vec_t v, input int exp_svc,
                           input logic [31:0] exp_eaddr);
    obs_t o;
    run_txn(v.addr, v.wdata, v.wstrb, o);
    chk({t, ".ready"}, 32'(o.done), 32'd1);
    chk({t, ".cycles"}, o.cyc, v.exp_cyc);
    chk({t, ".s_valid"}, 32'(o.sv_or), 32'(v.exp_sv));
    chk({t, ".onehot"}, 32'(o.multi), 32'd0);
    chk({t, ".sv_cycles"}, o.svc, exp_svc);
    chk({t, ".rdata"}, o.rdata, v.exp_rdata);
    chk({t, ".con_valid"}, 32'(o.con), 32'(v.exp_con));
    if (v.exp_con) chk({t, ".con_data"}, 32'(o.cdata), 32'(v.exp_cdata));
    chk({t, ".bus_err"}, 32'(o.err), 32'(v.exp_err));
    chk({t, ".stray_pulse"}, 32'(o.stray), 32'd0);
    if (v.exp_sv != 3'b000) begin
      chk({t, ".s_addr"}, o.saddr, v.addr);
      chk({t, ".s_wdata"}, o.swdata, v.wdata);
      chk({t, ".s_wstrb"}, 32'(o.swstrb), 32'(v.wstrb));
    end
    chk({t, ".halt"}, 32'(halt), 32'(v.exp_halt));
    chk({t, ".err_addr"}, err_addr, exp_eaddr);
  endtask

  // Reference address map: 0 = slave idx, 1 = halt, 2 = console, 3 = unmapped.
  function automatic void model(input logic [31:0] a, output int kind, output int idx);
    kind = 3; idx = 0;
    if (a[31:2] == HLT[31:2]) kind = 1;
    else if (a[31:2] == CON[31:2]) kind = 2;
    else begin
      for (int i = 0; i < 3; i++) begin
        if ((a & MASK[32*i +: 32]) == BASE[32*i +: 32]) begin
          kind = 0; idx = i;
          break;
        end
      end
    end
  endfunction

  vec_t vecs [12];

  initial begin
    vec_t v;
    obs_t o;
    int   kind, idx, cnt;

    vecs[0]  = '{32'h0000_0100, 32'h0, 4'h0, 0, 1, 3'b001, 32'hA5A5_0100, 0, 8'h00, 0, 0};
    vecs[1]  = '{32'h9000_0000, 32'h48, 4'h1, 0, 1, 3'b000, 32'h0, 1, 8'h48, 0, 0};
    vecs[2]  = '{32'h5000_0000, 32'h0, 4'h0, 0, 1, 3'b000, ERRD, 0, 8'h00, 1, 0};
    vecs[3]  = '{32'h3000_0000, 32'h0, 4'h0, 2, 3, 3'b001, 32'h95A5_0000, 0, 8'h00, 0, 0};
    vecs[4]  = '{32'h4000_0010, 32'h0, 4'h0, 1, 2, 3'b010, 32'h1A5A_0010, 0, 8'h00, 0, 0};
    vecs[5]  = '{32'h7000_0004, 32'h1234_5678, 4'hF, 0, 1, 3'b100, 32'h7F0F_0004, 0, 8'h00, 0, 0};
    vecs[6]  = '{32'h9000_0000, 32'hFFFF_FF55, 4'h0, 0, 1, 3'b000, 32'h0, 0, 8'h00, 0, 0};
    vecs[7]  = '{32'h8000_0000, 32'h0, 4'h0, 0, 1, 3'b000, 32'h0, 0, 8'h00, 0, 0};
    vecs[8]  = '{32'h8000_0000, 32'h1, 4'hF, 0, 1, 3'b000, 32'h0, 0, 8'h00, 0, 1};
    vecs[9]  = '{32'hB000_0008, 32'h0, 4'h0, 3, 4, 3'b100, 32'hBF0F_0008, 0, 8'h00, 0, 1};
    vecs[10] = '{32'h9000_0003, 32'h41, 4'h1, 0, 1, 3'b000, 32'h0, 1, 8'h41, 0, 1};
    vecs[11] = '{32'h5000_0000, 32'hCAFE, 4'hF, 0, 1, 3'b000, ERRD, 0, 8'h00, 1, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.mem_ready", 32'(mem_ready), 0);
    chk("rst.s_valid", 32'(s_valid), 0);
    chk("rst.con_valid", 32'(con_valid), 0);
    chk("rst.halt", 32'(halt), 0);
    chk("rst.bus_err", 32'(bus_err), 0);
    chk("rst.err_addr", err_addr, 0);
    chk("rst.mem_rdata", mem_rdata, 0);
    rst = 1'b0;

    for (int k = 0; k < 12; k++) begin
      v = vecs[k];
      for (int i = 0; i < 3; i++) lat[i] = v.lat;
      if (v.exp_err) m_err = v.addr;
      check_txn($sformatf("vec%0d", k), v, (v.exp_sv != 3'b000) ? v.exp_cyc : 0, m_err);
    end
    m_halt = 1'b1;

`ifdef MEMBUS_TIMEOUT_EN
    lat[1] = 1000;
    m_err  = 32'h4000_0020;
    v = '{32'h4000_0020, 32'h0, 4'h0, 0, 17, 3'b010, ERRD, 0, 8'h00, 1, 1};
    check_txn("timeout", v, 16, m_err);
    lat[1] = 0;
    v = '{32'h4000_0000, 32'h0, 4'h0, 0, 1, 3'b010, 32'h1A5A_0000, 0, 8'h00, 0, 1};
    check_txn("after_timeout", v, 1, m_err);
`endif

    for (int k = 0; k < 40; k++) begin
      int sel;
      sel = $urandom_range(0, 5);
      v.addr  = {4'($urandom_range(0, 15)), 26'($urandom), 2'b00};
      if (sel == 0) v.addr = HLT | 32'($urandom_range(0, 3));
      if (sel == 1) v.addr = CON | 32'($urandom_range(0, 3));
      v.wdata = $urandom;
      v.wstrb = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      for (int i = 0; i < 3; i++) lat[i] = $urandom_range(0, 3);
      model(v.addr, kind, idx);
      v.exp_cyc   = (kind == 0) ? 1 + lat[idx] : 1;
      v.exp_sv    = (kind == 0) ? 3'(1 << idx) : 3'b000;
      v.exp_rdata = (kind == 0) ? (v.addr ^ SEED[idx]) : (kind == 3) ? ERRD : 32'h0;
      v.exp_con   = (kind == 2) && (v.wstrb != 4'h0);
      v.exp_cdata = v.wdata[7:0];
      v.exp_err   = (kind == 3);
      if (kind == 1 && v.wstrb != 4'h0) m_halt = 1'b1;
      if (kind == 3) m_err = v.addr;
      v.exp_halt  = m_halt;
      check_txn($sformatf("rnd%0d", k), v, (kind == 0) ? v.exp_cyc : 0, m_err);
    end

    // Overlapped window with a stalled slave, then reset mid-wait.
    lat[0] = 50;
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h3000_0000; mem_wdata = '0; mem_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    chk("ovl.s_valid", 32'(s_valid), 32'b001);
    chk("ovl.mem_ready", 32'(mem_ready), 0);
    rst = 1'b1; mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.s_valid", 32'(s_valid), 0);
    chk("midrst.halt", 32'(halt), 0);
    chk("midrst.err_addr", err_addr, 0);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_ready || s_valid != 3'b000) cnt++;
    end
    chk("midrst.quiet", cnt, 0);
    m_halt = 1'b0; m_err = '0; lat[0] = 0;
    v = '{32'h0000_0200, 32'h0, 4'h0, 0, 1, 3'b001, 32'hA5A5_0200, 0, 8'h00, 0, 0};
    check_txn("post_rst", v, 1, m_err);

    run_txn(32'h0000_0300, 32'h0, 4'h0, o);
    chk("final.ready", 32'(o.done), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
